// File: rtl/toy_bus_arb_node_fetch_pld_type_toybusreq.sv
// Two-input round-robin merge node for ToyBusReq on the fetch request network.
// The winner is pushed into a 2-entry FIFO whose head drives out0; in*_rdy never depends on out0_rdy.
module toy_bus_arb_node_fetch_pld_type_toybusreq #(
    parameter int ADDR_W  = 32,
    parameter int STRB_W  = 32,
    parameter int DATA_W  = 256,
    parameter int ID_W    = 4,
    parameter int SB_W    = 10,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [STRB_W-1:0] in0_strb,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_opcode,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [STRB_W-1:0] in1_strb,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_opcode,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic [SB_W-1:0]   in1_sideband,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [ADDR_W-1:0] out0_addr,
    output logic [STRB_W-1:0] out0_strb,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_opcode,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [SB_W-1:0]   out0_sideband
);

    localparam int PLD_W = ADDR_W + STRB_W + DATA_W + 1 + 2 * ID_W + SB_W;

    logic [PLD_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic             prio_q, prio_d;

    logic             space_s, gnt_vld_s, gnt_idx_s, push_s, pop_s;
    logic [PLD_W-1:0] pld0_s, pld1_s, pld_in_s, head_s;

    assign pld0_s = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
    assign pld1_s = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};

    assign head_s   = rptr_q ? ent1_q : ent0_q;
    assign out0_vld = (count_q != 2'd0);
    assign {out0_addr, out0_strb, out0_data, out0_opcode,
            out0_src_id, out0_tgt_id, out0_sideband} = head_s;

    // Arbitration, handshakes and next-state for FIFO and priority.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        prio_d    = prio_q;
        gnt_vld_s = 1'b0;
        gnt_idx_s = 1'b0;

        // Space comes from the registered count only, so a pop cannot open room this cycle.
        space_s = (count_q < 2'd2);

        case ({in1_vld, in0_vld})
            2'b01: begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = 1'b0;
            end
            2'b10: begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = 1'b1;
            end
            2'b11: begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = prio_q;
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_idx_s = 1'b0;
            end
        endcase

        in0_rdy  = space_s && gnt_vld_s && !gnt_idx_s && in0_vld;
        in1_rdy  = space_s && gnt_vld_s &&  gnt_idx_s && in1_vld;
        push_s   = in0_rdy || in1_rdy;
        pop_s    = (count_q != 2'd0) && out0_rdy;
        pld_in_s = gnt_idx_s ? pld1_s : pld0_s;

        if (push_s) begin
            if (wptr_q) begin
                ent1_d = pld_in_s;
            end else begin
                ent0_d = pld_in_s;
            end
            wptr_d = ~wptr_q;
            prio_d = ~gnt_idx_s;
        end else begin
            wptr_d = wptr_q;
            prio_d = prio_q;
        end

        if (pop_s) begin
            rptr_d = ~rptr_q;
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards both entries and restores the initial priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            prio_q  <= 1'(RR_INIT);
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_toy_bus_arb_node_fetch_pld_type_toybusreq.sv
// Directed and randomised self-checking bench for the ToyBusReq two-input merge node.
module tb_toy_bus_arb_node_fetch_pld_type_toybusreq;

    localparam int PW = 32 + 32 + 256 + 1 + 4 + 4 + 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in0_vld = 1'b0, in1_vld = 1'b0, out0_rdy = 1'b0;
    logic          in0_rdy, in1_rdy, out0_vld;
    logic [PW-1:0] in0_pld = '0, in1_pld = '0, out_pld;

    logic [31:0]  in0_addr, in1_addr, out0_addr;
    logic [31:0]  in0_strb, in1_strb, out0_strb;
    logic [255:0] in0_data, in1_data, out0_data;
    logic         in0_opcode, in1_opcode, out0_opcode;
    logic [3:0]   in0_src_id, in1_src_id, out0_src_id;
    logic [3:0]   in0_tgt_id, in1_tgt_id, out0_tgt_id;
    logic [9:0]   in0_sideband, in1_sideband, out0_sideband;

    int n_cmp = 0;
    int n_bad = 0;

    assign {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband} = in0_pld;
    assign {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband} = in1_pld;
    assign out_pld = {out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id, out0_sideband};

    always #5 clk = ~clk;

    toy_bus_arb_node_fetch_pld_type_toybusreq dut (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_strb(in0_strb),
        .in0_data(in0_data), .in0_opcode(in0_opcode), .in0_src_id(in0_src_id),
        .in0_tgt_id(in0_tgt_id), .in0_sideband(in0_sideband),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_strb(in1_strb),
        .in1_data(in1_data), .in1_opcode(in1_opcode), .in1_src_id(in1_src_id),
        .in1_tgt_id(in1_tgt_id), .in1_sideband(in1_sideband),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_addr(out0_addr), .out0_strb(out0_strb),
        .out0_data(out0_data), .out0_opcode(out0_opcode), .out0_src_id(out0_src_id),
        .out0_tgt_id(out0_tgt_id), .out0_sideband(out0_sideband)
    );

    function automatic logic [PW-1:0] mk(input logic [31:0] a, input logic [3:0] s, input logic [3:0] t);
        return {a, 32'hF0F0_0000 ^ a, {8{a}}, a[0], s, t, a[9:0]};
    endfunction

    function automatic logic [PW-1:0] rnd(input logic [3:0] s);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) d = '1;
        return {32'($urandom), 32'($urandom), d, 1'($urandom), s, 4'($urandom), 10'($urandom)};
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in0_vld = 1'b0; in1_vld = 1'b0; out0_rdy = 1'b0;
        to_drive();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; #2;
        n_cmp++; if (out0_vld !== 1'b0) begin n_bad++; $display("FAIL rst_out_vld: got %b want 0", out0_vld); end
        n_cmp++; if ({in0_rdy, in1_rdy} !== 2'b00) begin n_bad++; $display("FAIL rst_rdy: got %b want 00", {in0_rdy, in1_rdy}); end
        n_cmp++; if (out_pld !== '0) begin n_bad++; $display("FAIL rst_pld: got %0h want 0", out_pld); end
        to_drive();
        rst = 1'b0;
        in0_vld = 1'b1; in0_pld = mk(32'h100, 4'd0, 4'd2); out0_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in0_rdy !== 1'b1) begin n_bad++; $display("FAIL first_rdy: got %b want 1", in0_rdy); end
        n_cmp++; if (out0_vld !== 1'b0) begin n_bad++; $display("FAIL first_vld0: got %b want 0", out0_vld); end
        to_drive();
        in0_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b1) begin n_bad++; $display("FAIL first_vld1: got %b want 1", out0_vld); end
        n_cmp++; if (out0_addr !== 32'h100 || out0_tgt_id !== 4'd2) begin
            n_bad++; $display("FAIL first_addr: got %0h/%0d want 100/2", out0_addr, out0_tgt_id); end
        to_drive();
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b0) begin n_bad++; $display("FAIL first_vld2: got %b want 0", out0_vld); end
        to_drive();
    endtask

    task automatic test_round_robin();
        logic [31:0] n0, n1;
        logic        a0, a1;
        logic [PW-1:0] exp;
        do_reset();
        n0 = 32'd0; n1 = 32'd0;
        out0_rdy = 1'b1; in0_vld = 1'b1; in1_vld = 1'b1;
        in0_pld = mk(32'h1000, 4'd0, 4'd1); in1_pld = mk(32'h2000, 4'd1, 4'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if ({in1_rdy, in0_rdy} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL rr_grant c%0d: got %b want %b", c, {in1_rdy, in0_rdy}, (c % 2 == 0) ? 2'b01 : 2'b10); end
            if (c >= 1) begin
                exp = (c % 2 == 1) ? mk(32'h1000 + 32'((c - 1) / 2), 4'd0, 4'd1)
                                   : mk(32'h2000 + 32'((c - 2) / 2), 4'd1, 4'd1);
                n_cmp++; if (out0_vld !== 1'b1 || out_pld !== exp) begin
                    n_bad++; $display("FAIL rr_out c%0d: got vld=%b addr=%0h want addr=%0h", c, out0_vld, out0_addr, exp[PW-1 -: 32]); end
            end
            a0 = in0_rdy; a1 = in1_rdy;
            to_drive();
            if (a0) begin n0 = n0 + 32'd1; in0_pld = mk(32'h1000 + n0, 4'd0, 4'd1); end
            if (a1) begin n1 = n1 + 32'd1; in1_pld = mk(32'h2000 + n1, 4'd1, 4'd1); end
        end
        in0_vld = 1'b0; in1_vld = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        out0_rdy = 1'b0; in0_vld = 1'b1; in0_pld = mk(32'hA0, 4'd0, 4'd3);
        @(negedge clk);
        n_cmp++; if (in0_rdy !== 1'b1) begin n_bad++; $display("FAIL full_accA: got %b want 1", in0_rdy); end
        to_drive(); in0_pld = mk(32'hB0, 4'd0, 4'd3);
        @(negedge clk);
        n_cmp++; if (in0_rdy !== 1'b1 || out_pld !== mk(32'hA0, 4'd0, 4'd3)) begin
            n_bad++; $display("FAIL full_accB: got rdy=%b addr=%0h want 1/a0", in0_rdy, out0_addr); end
        to_drive(); in0_pld = mk(32'hC0, 4'd0, 4'd3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (in0_rdy !== 1'b0 || out0_vld !== 1'b1 || out0_addr !== 32'hA0) begin
                n_bad++; $display("FAIL full_hold%0d: got rdy=%b vld=%b addr=%0h want 0/1/a0", c, in0_rdy, out0_vld, out0_addr); end
            to_drive();
        end
        out0_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in0_rdy !== 1'b0 || out_pld !== mk(32'hA0, 4'd0, 4'd3)) begin
            n_bad++; $display("FAIL full_popA: got rdy=%b addr=%0h want 0/a0", in0_rdy, out0_addr); end
        to_drive();
        @(negedge clk);
        n_cmp++; if (in0_rdy !== 1'b1 || out_pld !== mk(32'hB0, 4'd0, 4'd3)) begin
            n_bad++; $display("FAIL full_popB: got rdy=%b addr=%0h want 1/b0", in0_rdy, out0_addr); end
        to_drive(); in0_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b1 || out_pld !== mk(32'hC0, 4'd0, 4'd3)) begin
            n_bad++; $display("FAIL full_popC: got vld=%b addr=%0h want 1/c0", out0_vld, out0_addr); end
        to_drive();
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b0) begin n_bad++; $display("FAIL full_empty: got %b want 0", out0_vld); end
        to_drive();
    endtask

    task automatic test_full_pop_no_push();
        do_reset();
        out0_rdy = 1'b0; in0_vld = 1'b1; in0_pld = mk(32'h300, 4'd0, 4'd5);
        to_drive(); in0_pld = mk(32'h310, 4'd0, 4'd5);
        to_drive(); in0_vld = 1'b0;
        in1_vld = 1'b1; in1_pld = mk(32'h400, 4'd1, 4'd6); out0_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in1_rdy !== 1'b0 || out0_vld !== 1'b1 || out0_addr !== 32'h300) begin
            n_bad++; $display("FAIL fp_pop: got rdy=%b vld=%b addr=%0h want 0/1/300", in1_rdy, out0_vld, out0_addr); end
        to_drive();
        @(negedge clk);
        n_cmp++; if (in1_rdy !== 1'b1 || out0_addr !== 32'h310) begin
            n_bad++; $display("FAIL fp_next: got rdy=%b addr=%0h want 1/310", in1_rdy, out0_addr); end
        to_drive(); in1_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b1 || out_pld !== mk(32'h400, 4'd1, 4'd6)) begin
            n_bad++; $display("FAIL fp_in1: got vld=%b addr=%0h want 1/400", out0_vld, out0_addr); end
        to_drive();
        @(negedge clk);
        n_cmp++; if (out0_vld !== 1'b0) begin n_bad++; $display("FAIL fp_empty: got %b want 0", out0_vld); end
        to_drive();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out0_rdy = 1'b0; in0_vld = 1'b1; in0_pld = mk(32'h500, 4'd0, 4'd1);
        to_drive(); in0_pld = mk(32'h510, 4'd0, 4'd1);
        to_drive(); in0_vld = 1'b0;
        #1;
        n_cmp++; if (out0_vld !== 1'b1) begin n_bad++; $display("FAIL mid_full: got %b want 1", out0_vld); end
        rst = 1'b1; #1;
        n_cmp++; if (out0_vld !== 1'b0 || out_pld !== '0) begin
            n_bad++; $display("FAIL mid_async: got vld=%b addr=%0h want 0/0", out0_vld, out0_addr); end
        to_drive(); rst = 1'b0;
        in0_vld = 1'b1; in1_vld = 1'b1; out0_rdy = 1'b1;
        in0_pld = mk(32'h600, 4'd0, 4'd2); in1_pld = mk(32'h700, 4'd1, 4'd2);
        @(negedge clk);
        n_cmp++; if ({in1_rdy, in0_rdy} !== 2'b01 || out0_vld !== 1'b0) begin
            n_bad++; $display("FAIL mid_grant: got rdy=%b vld=%b want 01/0", {in1_rdy, in0_rdy}, out0_vld); end
        to_drive(); in0_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (in1_rdy !== 1'b1 || out_pld !== mk(32'h600, 4'd0, 4'd2)) begin
            n_bad++; $display("FAIL mid_out: got rdy=%b addr=%0h want 1/600", in1_rdy, out0_addr); end
        to_drive(); in1_vld = 1'b0;
    endtask

    task automatic test_random();
        logic [PW-1:0] q0[$], q1[$];
        logic [PW-1:0] exp;
        logic          a0, a1;
        int            w0, w1;
        localparam int N = 3000;
        do_reset();
        w0 = 0; w1 = 0;
        for (int cyc = 0; cyc < N; cyc++) begin
            if (cyc < N - 8) begin
                if (!in0_vld && $urandom_range(0, 1) == 1) begin in0_vld = 1'b1; in0_pld = rnd(4'd0); end
                if (!in1_vld && $urandom_range(0, 1) == 1) begin in1_vld = 1'b1; in1_pld = rnd(4'd1); end
                out0_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                out0_rdy = 1'b1;
            end
            @(negedge clk);
            a0 = in0_vld && in0_rdy; a1 = in1_vld && in1_rdy;
            n_cmp++; if (a0 && a1) begin n_bad++; $display("FAIL rnd_dual cyc%0d: got 2 accepts want <=1", cyc); end
            if (out0_vld && out0_rdy) begin
                n_cmp++;
                if (out0_src_id == 4'd0 && q0.size() > 0) begin
                    exp = q0.pop_front();
                    if (out_pld !== exp) begin n_bad++; $display("FAIL rnd_pld0 cyc%0d: got %0h want %0h", cyc, out_pld, exp); end
                end else if (out0_src_id == 4'd1 && q1.size() > 0) begin
                    exp = q1.pop_front();
                    if (out_pld !== exp) begin n_bad++; $display("FAIL rnd_pld1 cyc%0d: got %0h want %0h", cyc, out_pld, exp); end
                end else begin
                    n_bad++; $display("FAIL rnd_spurious cyc%0d: got src %0d want a queued request", cyc, out0_src_id);
                end
            end
            if (a0) begin
                q0.push_back(in0_pld);
                n_cmp++; if (w0 > 1) begin n_bad++; $display("FAIL rnd_starve0 cyc%0d: got wait %0d want <=1", cyc, w0); end
                w0 = 0;
            end else if (in0_vld && a1) begin
                w0++;
            end
            if (a1) begin
                q1.push_back(in1_pld);
                n_cmp++; if (w1 > 1) begin n_bad++; $display("FAIL rnd_starve1 cyc%0d: got wait %0d want <=1", cyc, w1); end
                w1 = 0;
            end else if (in1_vld && a0) begin
                w1++;
            end
            to_drive();
            if (a0) in0_vld = 1'b0;
            if (a1) in1_vld = 1'b0;
        end
        #1;
        n_cmp++; if (q0.size() != 0 || q1.size() != 0 || out0_vld !== 1'b0 || in0_vld || in1_vld) begin
            n_bad++; $display("FAIL rnd_drain: got q0=%0d q1=%0d vld=%b want 0/0/0", q0.size(), q1.size(), out0_vld); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fifo_full();
        test_full_pop_no_push();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
